// File: rtl/bcd_run_ctrl_if.sv
// Button inputs and BCD count outputs between the run controller and its neighbours.
interface bcd_run_ctrl_if;
  logic       btn_run;
  logic       btn_dir;
  logic       btn_clr;
  logic [3:0] dig_uni;
  logic [3:0] dig_dec;
  logic       running;
  logic       dir_down;
  logic       wrap;

  modport master (
    output btn_run, btn_dir, btn_clr,
    input  dig_uni, dig_dec, running, dir_down, wrap
  );

  modport slave (
    input  btn_run, btn_dir, btn_clr,
    output dig_uni, dig_dec, running, dir_down, wrap
  );
endinterface

// File: rtl/bcd_run_ctrl.sv
// Debounced run/dir/clear buttons driving a prescaled two-digit BCD up/down counter.
module bcd_run_ctrl #(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_run_ctrl_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 2)   ? $clog2(TICK_DIV)   : 1;
  localparam int unsigned DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  // Button bit order: [0] run, [1] dir, [2] clear
  logic [2:0]    raw, s1, s2, deb, deb_q, press;
  logic [DW-1:0] dcnt [3];

  assign raw = {bus.btn_clr, bus.btn_dir, bus.btn_run};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 3; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  state_t        state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [3:0]    uni, uni_n, dec, dec_n;
  logic          dir, dir_n, wrp, wrp_n;
  logic          step;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= STOP;
      pre   <= '0;
      uni   <= '0;
      dec   <= '0;
      dir   <= 1'b0;
      wrp   <= 1'b0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      uni   <= uni_n;
      dec   <= dec_n;
      dir   <= dir_n;
      wrp   <= wrp_n;
    end
  end

  assign step = (state == RUN) && (pre == PW'(TICK_DIV - 1));

  // Step uses pre-edge state/direction; later assignments give clear the final word.
  always_comb begin
    state_n = state;
    pre_n   = '0;
    uni_n   = uni;
    dec_n   = dec;
    dir_n   = dir;
    wrp_n   = 1'b0;

    if (state == RUN && !step) pre_n = pre + PW'(1);

    if (step) begin
      if (!dir) begin
        if (uni < 4'd9) begin
          uni_n = uni + 4'd1;
        end else begin
          uni_n = 4'd0;
          if (dec == 4'd9) begin
            dec_n = 4'd0;
            wrp_n = 1'b1;
          end else begin
            dec_n = dec + 4'd1;
          end
        end
      end else begin
        if (uni > 4'd0) begin
          uni_n = uni - 4'd1;
        end else begin
          uni_n = 4'd9;
          if (dec == 4'd0) begin
            dec_n = 4'd9;
            wrp_n = 1'b1;
          end else begin
            dec_n = dec - 4'd1;
          end
        end
      end
    end

    if (press[0]) begin
      state_n = (state == RUN) ? STOP : RUN;
      pre_n   = '0;
    end

    if (press[1]) dir_n = ~dir;

    if (press[2]) begin
      uni_n   = 4'd0;
      dec_n   = 4'd0;
      pre_n   = '0;
      state_n = STOP;
      wrp_n   = 1'b0;
    end
  end

  assign bus.dig_uni  = uni;
  assign bus.dig_dec  = dec;
  assign bus.running  = (state == RUN);
  assign bus.dir_down = dir;
  assign bus.wrap     = wrp;

endmodule

// File: doc/bcd_run_ctrl.md
Name: bcd_run_ctrl

Overview:
- Upstream stage of the two-digit display multiplexer. Turns three raw push-buttons (run/pause, direction, clear) into a two-digit BCD up/down count, 00..99, stepped at a prescaled rate.
- Outputs dig_uni/dig_dec feed the mux unit and tens inputs directly.
- Replaces the free-running binary counter and the divide/modulo digit split with native BCD arithmetic.

Parameters:
- TICK_DIV, 1000: clk cycles per count step while running; must be ≥2.
- DEB_CYCLES, 16: consecutive stable synchronized samples needed to accept a button level change; must be ≥2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-high (rst_n=1 resets).
- btn_run  input  1  raw run/pause button, asynchronous, active-high.
- btn_dir  input  1  raw direction-toggle button, asynchronous, active-high.
- btn_clr  input  1  raw clear button, asynchronous, active-high.
- dig_uni  output  4  BCD units digit, 0..9.
- dig_dec  output  4  BCD tens digit, 0..9.
- running  output  1  1 when the FSM is in RUN.
- dir_down  output  1  0 = count up, 1 = count down.
- wrap  output  1  one-cycle pulse on 99→00 (up) or 00→99 (down).

Behaviour:
- Reset (rst_n=1, async) clears all of the following:
  - dig_uni=0, dig_dec=0, running=0, dir_down=0, wrap=0.
  - Prescaler=0.
  - Synchronizer, debounce and edge registers=0.
  - FSM=STOP.
- Per button, input conditioning:
  - 2-FF synchronizer s1→s2.
  - Debouncer holds level deb and counter dcnt.
    - If s2==deb: dcnt←0.
    - Else if dcnt==DEB_CYCLES-1: deb←s2, dcnt←0.
    - Else: dcnt←dcnt+1.
  - Press pulse = deb & ~deb_q, where deb_q is deb delayed one cycle. Only rising edges act; release does nothing.
  - Glitches shorter than DEB_CYCLES samples are rejected.
  - Latency: raw held high from before edge k takes effect at edge k+DEB_CYCLES+2.
- Outputs running, dir_down, dig_uni, dig_dec and wrap are all registered.
- FSM states:
  - STOP: prescaler held at 0; digits frozen. Run press → RUN.
  - RUN: prescaler counts 0..TICK_DIV-1.
    - At TICK_DIV-1: prescaler←0 and one count step occurs on the same edge.
    - Run press → STOP.
  - Entering RUN clears the prescaler, so the first step comes TICK_DIV cycles after the entry edge. The sub-tick phase is discarded on pause.
- Count step, up:
  - If uni<9: uni+1.
  - Else uni←0 and dec+1.
  - At 99: →00 with wrap=1.
- Count step, down:
  - If uni>0: uni-1.
  - Else uni←9 and dec-1.
  - At 00: →99 with wrap=1.
- wrap is high for exactly the cycle after the wrapping edge; otherwise 0.
- Dir press: dir_down←~dir_down in either state. Prescaler is unaffected.
- Clear press: digits←00, prescaler←0, FSM←STOP, wrap←0.
- Simultaneous events on one edge:
  - Clear has priority over step, run toggle and wrap. Direction still toggles if dir is pressed on the same edge.
  - A step uses the FSM state and direction from before the edge. A step coinciding with a run press or dir press completes with the old direction/state.
- Digits never leave 0..9; no illegal BCD values are reachable.
- Holding a button produces exactly one action.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for clk. Release requires no button to be re-pressed.

Test Plan:
- Settings: DEB_CYCLES=4, TICK_DIV=10.
- Reset: assert rst_n=1 mid-count → outputs 0, 0, 0, 0, 0 immediately, without waiting for a clk edge. Deassert with buttons idle → digits stay 00 and running=0 for 100 cycles.
- Debounce/latency:
  - 3-cycle btn_run pulse → no change.
  - btn_run held 20 cycles from before edge k → running=1 at edge k+6, exactly once.
- Up count/wrap:
  - Run from 00 → first step to 01 after 10 cycles.
  - 09→10 carry is correct.
  - 99→00 with wrap=1 for exactly one cycle.
- Down count/wrap: from 00, dir press then run → 99 with wrap pulse, then 98. 10→09 borrow is correct.
- Pause/resume:
  - Pause at 42 with prescaler mid-way → digits hold for 50 cycles.
  - Resume → next step exactly 10 cycles after entry.
- Simultaneous events:
  - Clear press on a step edge at 57 → 00, STOP, wrap=0.
  - Dir press on a step edge at 30 (up) → 31, and the next step gives 30.
